// File: rtl/seq_det_pkg.sv
// Shared definitions for the 111/000 sequence detector and its hit monitor.
// Holds the state encoding, polarity constants and default sizing.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic POL_ZERO = 1'b0;
  localparam logic POL_ONE  = 1'b1;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_BURST_W  = 4;
  localparam int unsigned DEF_ALARM_TH = 4;

endpackage

// File: rtl/seq_hit_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// When clr and inc coincide the count restarts from zero, giving 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d, base;

  always_comb begin
    base = clr ? '0 : q_q;
    q_d  = (inc && (base != '1)) ? base + 1'b1 : base;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_hit_monitor.sv
// Hit classifier and burst tracker fed by the Mealy 111/000 detector.
// Keeps saturating hit statistics, burst lengths and a sticky burst alarm.
module seq_hit_monitor
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned BURST_W  = DEF_BURST_W,
  parameter int unsigned ALARM_TH = DEF_ALARM_TH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               y,
  input  logic               clr,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   ones_count,
  output logic [CNT_W-1:0]   zeros_count,
  output logic [BURST_W-1:0] burst_len,
  output logic [BURST_W-1:0] max_burst,
  output logic [BURST_W-1:0] last_burst,
  output logic               burst_done,
  output logic               burst_pol,
  output logic               alarm
);

  localparam logic [BURST_W-1:0] TH = BURST_W'(ALARM_TH);

  state_e             state_q, state_d;
  logic               pol_q, pol_d;
  logic [BURST_W-1:0] max_q, max_d;
  logic [BURST_W-1:0] last_q, last_d;
  logic               done_q, done_d;
  logic               alarm_q, alarm_d;
  logic               start, cont;
  logic [BURST_W-1:0] blen_nxt;
  logic               hit_ok;

  assign hit_ok = y & ~clr;

  sat_counter #(.W(CNT_W)) u_hit (
    .clk(clk), .rst(rst), .inc(hit_ok), .clr(clr), .q(hit_count)
  );

  sat_counter #(.W(CNT_W)) u_ones (
    .clk(clk), .rst(rst), .inc(hit_ok & x), .clr(clr), .q(ones_count)
  );

  sat_counter #(.W(CNT_W)) u_zeros (
    .clk(clk), .rst(rst), .inc(hit_ok & ~x), .clr(clr), .q(zeros_count)
  );

  // A burst start is expressed as clear-plus-increment so the counter lands on 1.
  sat_counter #(.W(BURST_W)) u_blen (
    .clk(clk), .rst(rst), .inc(start | cont), .clr(clr | start), .q(burst_len)
  );

  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    max_d   = max_q;
    last_d  = last_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;
    start   = 1'b0;
    cont    = 1'b0;

    if (clr) begin
      state_d = IDLE;
      pol_d   = POL_ZERO;
      max_d   = '0;
      last_d  = '0;
      alarm_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (y) begin
            state_d = RUN;
            start   = 1'b1;
            pol_d   = x;
          end
        end
        RUN: begin
          if (!y) begin
            state_d = IDLE;
            last_d  = burst_len;
            done_d  = 1'b1;
          end else if (x == pol_q) begin
            cont = 1'b1;
          end else begin
            last_d = burst_len;
            done_d = 1'b1;
            start  = 1'b1;
            pol_d  = x;
          end
        end
      endcase
    end

    // Mirror of the burst counter's next value, needed for max and alarm.
    blen_nxt = burst_len;
    if (start)                            blen_nxt = BURST_W'(1);
    else if (cont && (burst_len != '1))   blen_nxt = burst_len + 1'b1;

    if (start || cont) begin
      if (blen_nxt > max_q) max_d   = blen_nxt;
      if (blen_nxt >= TH)   alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pol_q   <= POL_ZERO;
      max_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pol_q   <= pol_d;
      max_q   <= max_d;
      last_q  <= last_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  assign max_burst  = max_q;
  assign last_burst = last_q;
  assign burst_done = done_q;
  assign burst_pol  = pol_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed bench for seq_hit_monitor: default-sized and narrow instances share stimulus,
// a reference model pushes expected outputs that are popped after each edge.
module tb_seq_hit_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0, y = 1'b0, clr = 1'b0;

  logic [7:0] hit_a, ones_a, zeros_a;
  logic [3:0] blen_a, maxb_a, lastb_a;
  logic       done_a, pol_a, alarm_a;
  logic [2:0] hit_b, ones_b, zeros_b;
  logic [1:0] blen_b, maxb_b, lastb_b;
  logic       done_b, pol_b, alarm_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_hit_monitor #(.CNT_W(8), .BURST_W(4), .ALARM_TH(4)) dut_a (
    .clk(clk), .rst(rst), .x(x), .y(y), .clr(clr),
    .hit_count(hit_a), .ones_count(ones_a), .zeros_count(zeros_a),
    .burst_len(blen_a), .max_burst(maxb_a), .last_burst(lastb_a),
    .burst_done(done_a), .burst_pol(pol_a), .alarm(alarm_a)
  );

  seq_hit_monitor #(.CNT_W(3), .BURST_W(2), .ALARM_TH(3)) dut_b (
    .clk(clk), .rst(rst), .x(x), .y(y), .clr(clr),
    .hit_count(hit_b), .ones_count(ones_b), .zeros_count(zeros_b),
    .burst_len(blen_b), .max_burst(maxb_b), .last_burst(lastb_b),
    .burst_done(done_b), .burst_pol(pol_b), .alarm(alarm_b)
  );

  typedef struct {
    int hit, ones, zeros, blen, maxb, lastb, done, pol, alarm, run;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t sb[$];
  mdl_t ma, mb;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic mdl_t mstep(mdl_t s, logic rn, logic xi, logic yi, logic ci,
                                 int cmax, int bmax, int th);
    mdl_t n = s;
    if (!rn || ci) begin
      n = '{default: 0};
      return n;
    end
    n.done = 0;
    if (yi) begin
      n.hit = sat(s.hit + 1, cmax);
      if (xi) n.ones  = sat(s.ones + 1, cmax);
      else    n.zeros = sat(s.zeros + 1, cmax);
      if (s.run == 0) begin
        n.run = 1; n.blen = 1; n.pol = int'(xi);
      end else if (int'(xi) == s.pol) begin
        n.blen = sat(s.blen + 1, bmax);
      end else begin
        n.lastb = s.blen; n.done = 1; n.blen = 1; n.pol = int'(xi);
      end
      if (n.blen > n.maxb) n.maxb = n.blen;
      if (n.blen >= th)    n.alarm = 1;
    end else if (s.run != 0) begin
      n.run = 0; n.lastb = s.blen; n.done = 1;
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string p, input mdl_t e);
    cmp({p, ".A.hit"},   32'(hit_a),   e.hit);
    cmp({p, ".A.ones"},  32'(ones_a),  e.ones);
    cmp({p, ".A.zeros"}, 32'(zeros_a), e.zeros);
    cmp({p, ".A.blen"},  32'(blen_a),  e.blen);
    cmp({p, ".A.maxb"},  32'(maxb_a),  e.maxb);
    cmp({p, ".A.lastb"}, 32'(lastb_a), e.lastb);
    cmp({p, ".A.done"},  32'(done_a),  e.done);
    cmp({p, ".A.pol"},   32'(pol_a),   e.pol);
    cmp({p, ".A.alarm"}, 32'(alarm_a), e.alarm);
  endtask

  task automatic chk_b(input string p, input mdl_t e);
    cmp({p, ".B.hit"},   32'(hit_b),   e.hit);
    cmp({p, ".B.ones"},  32'(ones_b),  e.ones);
    cmp({p, ".B.zeros"}, 32'(zeros_b), e.zeros);
    cmp({p, ".B.blen"},  32'(blen_b),  e.blen);
    cmp({p, ".B.maxb"},  32'(maxb_b),  e.maxb);
    cmp({p, ".B.lastb"}, 32'(lastb_b), e.lastb);
    cmp({p, ".B.done"},  32'(done_b),  e.done);
    cmp({p, ".B.pol"},   32'(pol_b),   e.pol);
    cmp({p, ".B.alarm"}, 32'(alarm_b), e.alarm);
  endtask

  task automatic step(input string p, input logic rn, input logic xi, input logic yi,
                      input logic ci);
    exp_t e;
    @(negedge clk);
    rst = rn; x = xi; y = yi; clr = ci;
    ma = mstep(ma, rn, xi, yi, ci, 255, 15, 4);
    mb = mstep(mb, rn, xi, yi, ci, 7, 3, 3);
    sb.push_back('{a: ma, b: mb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_a(p, e.a);
    chk_b(p, e.b);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};

    // 1: reset held with hits present, then first hit after release
    step("t1.rst0", 1'b0, 1'b1, 1'b1, 1'b0);
    step("t1.rst1", 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("t1.hit_in_reset", 32'(hit_a), 0);
    step("t1.first", 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("t1.hit_after_release", 32'(hit_a), 1);
    step("t1.end", 1'b1, 1'b0, 1'b0, 1'b0);
    step("t1.clr", 1'b1, 1'b0, 1'b0, 1'b1);

    // 2: 000 hits
    step("t2.s0", 1'b1, 1'b0, 1'b0, 1'b0);
    step("t2.s1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("t2.s2", 1'b1, 1'b0, 1'b1, 1'b0);
    step("t2.s3", 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("t2.zeros", 32'(zeros_a), 2);
    cmp("t2.blen", 32'(blen_a), 2);
    cmp("t2.pol", 32'(pol_a), 0);
    step("t2.s4", 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("t2.done", 32'(done_a), 1);
    cmp("t2.last", 32'(lastb_a), 2);
    cmp("t2.max", 32'(maxb_a), 2);
    cmp("t2.alarm", 32'(alarm_a), 0);

    // 3: 111 burst reaching the alarm threshold
    step("t3.s0", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t3.s1", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t3.s2", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t3.s3", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t3.s4", 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("t3.alarm_before_th", 32'(alarm_a), 0);
    step("t3.s5", 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("t3.ones", 32'(ones_a), 4);
    cmp("t3.blen", 32'(blen_a), 4);
    cmp("t3.alarm_at_th", 32'(alarm_a), 1);
    step("t3.s6", 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t3.done", 32'(done_a), 1);
    cmp("t3.last", 32'(lastb_a), 4);
    cmp("t3.max", 32'(maxb_a), 4);
    step("t3.s7", 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t3.done_once", 32'(done_a), 0);
    cmp("t3.alarm_sticky", 32'(alarm_a), 1);

    // 4: clr coinciding with a hit drops the hit
    step("t4.pre", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t4.clr", 1'b1, 1'b1, 1'b1, 1'b1);
    cmp("t4.hit_cleared", 32'(hit_a), 0);
    cmp("t4.alarm_cleared", 32'(alarm_a), 0);
    cmp("t4.blen_cleared", 32'(blen_a), 0);
    step("t4.hit", 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("t4.hit_after", 32'(hit_a), 1);
    cmp("t4.blen_after", 32'(blen_a), 1);
    step("t4.end", 1'b1, 1'b0, 1'b0, 1'b0);

    // 5: saturation on the narrow instance
    step("t5.clr", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("t5.run1", 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("t5.hit_sat", 32'(hit_b), 7);
    cmp("t5.blen_sat", 32'(blen_b), 3);
    cmp("t5.max_sat", 32'(maxb_b), 3);
    cmp("t5.no_done", 32'(done_b), 0);
    cmp("t5.hit_wide", 32'(hit_a), 10);
    step("t5.end1", 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t5.last_sat", 32'(lastb_b), 3);
    step("t5.clr2", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("t5.run0", 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("t5.zeros_sat", 32'(zeros_b), 7);
    cmp("t5.ones_zero", 32'(ones_b), 0);
    step("t5.end0", 1'b1, 1'b0, 1'b0, 1'b0);

    // 6: polarity flip without a gap
    step("t6.clr", 1'b1, 1'b0, 1'b0, 1'b1);
    step("t6.h0", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t6.h1", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t6.flip", 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("t6.done", 32'(done_a), 1);
    cmp("t6.last", 32'(lastb_a), 2);
    cmp("t6.blen", 32'(blen_a), 1);
    cmp("t6.pol", 32'(pol_a), 0);
    step("t6.end", 1'b1, 1'b0, 1'b0, 1'b0);

    // 7: asynchronous reset mid-burst, no burst_done afterwards
    step("t7.h0", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t7.h1", 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    cmp("t7.async_hit", 32'(hit_a), 0);
    cmp("t7.async_blen", 32'(blen_a), 0);
    cmp("t7.async_pol", 32'(pol_a), 0);
    cmp("t7.async_max", 32'(maxb_a), 0);
    ma = '{default: 0};
    mb = '{default: 0};
    step("t7.held", 1'b0, 1'b0, 1'b0, 1'b0);
    step("t7.rel", 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t7.no_done", 32'(done_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
